// File: rtl/threewire_slave_ctrl.sv
// Responder end of a 3-wire serial register link.
// Deserialises R/W, address and data; serialises read data back MSB first.
module threewire_slave_ctrl #(
  parameter int TWS_ADDRESS_BITS = 10,
  parameter int TWS_DATA_BITS    = 32
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_tw_clock,
  input  logic                        in_tw_cs,
  inout  wire                         io_tw_data,
  output logic                        out_tw_dir,
  output logic [TWS_ADDRESS_BITS-1:0] out_reg_addr,
  output logic [TWS_DATA_BITS-1:0]    out_reg_wr_data,
  output logic                        out_reg_wr,
  output logic                        out_reg_rd,
  input  logic [TWS_DATA_BITS-1:0]    in_reg_rd_data,
  output logic                        out_busy
);

  localparam int AW   = TWS_ADDRESS_BITS;
  localparam int DW   = TWS_DATA_BITS;
  localparam int MAXW = (AW > DW) ? AW : DW;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, RSTB, RLAT,
    RDATA, WDATA, WSTB, DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]    clk_s, cs_s, dat_s;
  logic          clk_d;
  logic          rise, fall, cs_hi, sdat;
  logic          rw, dir, cnt_zero;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_sh, addr_nx, reg_addr;
  logic [DW-1:0] data_sh, data_nx, tx_sh, reg_wr_data;

  // cs syncs reset to idle-high so a released bus never looks selected
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      clk_s <= 2'b00;
      cs_s  <= 2'b11;
      dat_s <= 2'b00;
      clk_d <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], in_tw_clock};
      cs_s  <= {cs_s[0], in_tw_cs};
      dat_s <= {dat_s[0], io_tw_data};
      clk_d <= clk_s[1];
    end
  end

  assign rise     = clk_s[1] & ~clk_d;
  assign fall     = ~clk_s[1] & clk_d;
  assign cs_hi    = cs_s[1];
  assign sdat     = dat_s[1];
  assign cnt_zero = (cnt == '0);
  assign addr_nx  = {addr_sh[AW-2:0], sdat};
  assign data_nx  = {data_sh[DW-2:0], sdat};

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state != IDLE && cs_hi) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (!cs_hi) state_nx = CMD;
        CMD:   if (rise) state_nx = ADDR;
        ADDR:  if (rise && cnt_zero)
                 state_nx = rw ? WDATA : RSTB;
        RSTB:  state_nx = RLAT;
        RLAT:  state_nx = RDATA;
        RDATA: if (fall && dir && cnt_zero)
                 state_nx = DONE;
        WDATA: if (rise && cnt_zero) state_nx = WSTB;
        WSTB:  state_nx = DONE;
        DONE:  state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    out_reg_wr = 1'b0;
    out_reg_rd = 1'b0;
    unique case (1'b1)
      (state == WSTB): out_reg_wr = 1'b1;
      (state == RSTB): out_reg_rd = 1'b1;
      default: ;
    endcase
    out_busy = (state != IDLE) && !cs_hi;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rw          <= 1'b0;
      dir         <= 1'b0;
      cnt         <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      tx_sh       <= '0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
    end else if (state != IDLE && cs_hi) begin
      dir <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dir     <= 1'b0;
          addr_sh <= '0;
          data_sh <= '0;
          tx_sh   <= '0;
        end
        CMD: if (rise) begin
          rw  <= sdat;
          cnt <= CW'(AW - 1);
        end
        ADDR: if (rise) begin
          addr_sh <= addr_nx;
          if (cnt_zero) begin
            reg_addr <= addr_nx;
            cnt      <= CW'(DW - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RLAT: tx_sh <= in_reg_rd_data;
        // first fall turns the bus, later falls shift, the one after the LSB releases
        RDATA: if (fall) begin
          if (!dir) begin
            dir <= 1'b1;
          end else if (cnt_zero) begin
            dir <= 1'b0;
          end else begin
            tx_sh <= {tx_sh[DW-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
          end
        end
        WDATA: if (rise) begin
          data_sh <= data_nx;
          if (cnt_zero) reg_wr_data <= data_nx;
          else          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign io_tw_data      = dir ? tx_sh[DW-1] : 1'bz;
  assign out_tw_dir      = dir;
  assign out_reg_addr    = reg_addr;
  assign out_reg_wr_data = reg_wr_data;

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// Directed bench for threewire_slave_ctrl: bus master, register file model,
// strobe scoreboard and read-data queue.
module tb_threewire_slave_ctrl;

  localparam int HALF = 8;

  typedef struct {
    logic        wr;
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        tw_clk, tw_cs;
  logic        m_oe, m_dat;
  wire         io_tw_data;
  logic        out_tw_dir, out_reg_wr, out_reg_rd, out_busy;
  logic [9:0]  out_reg_addr;
  logic [31:0] out_reg_wr_data, in_reg_rd_data;

  logic        pl_en;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;
  logic [31:0] mem [0:1023];

  exp_t        sbq[$];
  logic [31:0] rdq[$];
  int          checks = 0;
  int          errors = 0;

  assign io_tw_data = m_oe ? m_dat : 1'bz;

  always #5 in_clk = ~in_clk;

  threewire_slave_ctrl dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_tw_clock     (tw_clk),
    .in_tw_cs        (tw_cs),
    .io_tw_data      (io_tw_data),
    .out_tw_dir      (out_tw_dir),
    .out_reg_addr    (out_reg_addr),
    .out_reg_wr_data (out_reg_wr_data),
    .out_reg_wr      (out_reg_wr),
    .out_reg_rd      (out_reg_rd),
    .in_reg_rd_data  (in_reg_rd_data),
    .out_busy        (out_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // register file answering the strobes
  always @(negedge in_clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (out_reg_wr) mem[out_reg_addr] <= out_reg_wr_data;
    if (out_reg_rd) in_reg_rd_data <= mem[out_reg_addr];
  end

  always @(negedge in_clk) begin
    if (!in_rst && (out_reg_wr || out_reg_rd)) begin
      exp_t e;
      chk("strobe_exclusive", 32'(out_reg_wr & out_reg_rd), 32'd0);
      chk("strobe_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("strobe_kind", 32'(out_reg_wr), 32'(e.wr));
        chk("strobe_addr", 32'(out_reg_addr), 32'(e.a));
        if (e.wr) chk("strobe_wdata", out_reg_wr_data, e.d);
      end
    end
  end

  task automatic tw_bit(input logic b, output logic s, output logic d);
    m_dat = b;
    repeat (HALF) @(negedge in_clk);
    s = io_tw_data;
    d = out_tw_dir;
    tw_clk = 1'b1;
    repeat (HALF) @(negedge in_clk);
    tw_clk = 1'b0;
  endtask

  task automatic frame(input logic rw, input logic [9:0] a,
                       input logic [31:0] wd, input int nd,
                       output logic [31:0] rd);
    logic s, d;
    rd = '0;
    m_oe = 1'b1;
    tw_cs = 1'b0;
    repeat (4) @(negedge in_clk);
    tw_bit(rw, s, d);
    chk("busy_in_frame", 32'(out_busy), 32'd1);
    for (int i = 9; i >= 0; i--) tw_bit(a[i], s, d);
    if (!rw) m_oe = 1'b0;
    for (int i = 0; i < nd; i++) begin
      tw_bit(rw ? wd[31 - (i % 32)] : 1'b0, s, d);
      if (rw) chk("dir_write", 32'(d), 32'd0);
      else if (i < 32) rd = {rd[30:0], s};
      if (!rw && i == 31) chk("dir_read_last", 32'(d), 32'd1);
      if (!rw && i >= 32) chk("dir_read_extra", 32'(d), 32'd0);
    end
  endtask

  task automatic end_frame(input int gap);
    tw_cs = 1'b1;
    m_oe = 1'b1;
    repeat (gap) @(negedge in_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdv;
    in_rst = 1'b1;
    tw_clk = 1'b0;
    tw_cs  = 1'b1;
    m_oe   = 1'b1;
    m_dat  = 1'b0;
    pl_en  = 1'b0;
    pl_a   = '0;
    pl_d   = '0;
    repeat (3) @(negedge in_clk);
    chk("rst_dir", 32'(out_tw_dir), 32'd0);
    chk("rst_addr", 32'(out_reg_addr), 32'd0);
    chk("rst_wdata", out_reg_wr_data, 32'd0);
    chk("rst_wr", 32'(out_reg_wr), 32'd0);
    chk("rst_rd", 32'(out_reg_rd), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    in_rst = 1'b0;
    pl_a = 10'h2AA;
    pl_d = 32'h12345678;
    pl_en = 1'b1;
    repeat (2) @(negedge in_clk);
    pl_en = 1'b0;
    repeat (2) @(negedge in_clk);

    sbq.push_back('{1'b1, 10'h155, 32'hDEADBEEF});
    frame(1'b1, 10'h155, 32'hDEADBEEF, 32, rdv);
    end_frame(6);
    chk("wr_addr", 32'(out_reg_addr), 32'h155);
    chk("wr_data", out_reg_wr_data, 32'hDEADBEEF);

    sbq.push_back('{1'b0, 10'h2AA, 32'h0});
    rdq.push_back(32'h12345678);
    frame(1'b0, 10'h2AA, 32'h0, 32, rdv);
    repeat (5) @(negedge in_clk);
    chk("rd_dir_off", 32'(out_tw_dir), 32'd0);
    chk("rd_data", rdv, rdq.pop_front());
    end_frame(6);

    frame(1'b1, 10'h0AB, 32'hCAFEF00D, 20, rdv);
    tw_cs = 1'b1;
    repeat (3) @(negedge in_clk);
    chk("abort_busy", 32'(out_busy), 32'd0);
    chk("abort_dir", 32'(out_tw_dir), 32'd0);
    end_frame(6);
    chk("abort_no_write", out_reg_wr_data, 32'hDEADBEEF);

    sbq.push_back('{1'b0, 10'h2AA, 32'h0});
    rdq.push_back(32'h12345678);
    frame(1'b0, 10'h2AA, 32'h0, 40, rdv);
    chk("rd40_data", rdv, rdq.pop_front());
    chk("rd40_dir_off", 32'(out_tw_dir), 32'd0);
    end_frame(6);

    sbq.push_back('{1'b0, 10'h2AA, 32'h0});
    frame(1'b0, 10'h2AA, 32'h0, 10, rdv);
    in_rst = 1'b1;
    #1;
    chk("rst_mid_dir", 32'(out_tw_dir), 32'd0);
    chk("rst_mid_busy", 32'(out_busy), 32'd0);
    chk("rst_mid_addr", 32'(out_reg_addr), 32'd0);
    tw_cs = 1'b1;
    m_oe = 1'b1;
    repeat (2) @(negedge in_clk);
    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);
    sbq.push_back('{1'b1, 10'h001, 32'h00000001});
    frame(1'b1, 10'h001, 32'h00000001, 32, rdv);
    end_frame(6);
    chk("post_rst_addr", 32'(out_reg_addr), 32'h001);
    chk("post_rst_data", out_reg_wr_data, 32'h00000001);

    sbq.push_back('{1'b1, 10'h3FF, 32'hFFFFFFFF});
    frame(1'b1, 10'h3FF, 32'hFFFFFFFF, 32, rdv);
    end_frame(3);
    sbq.push_back('{1'b0, 10'h3FF, 32'h0});
    rdq.push_back(32'hFFFFFFFF);
    frame(1'b0, 10'h3FF, 32'h0, 32, rdv);
    repeat (5) @(negedge in_clk);
    chk("b2b_dir_off", 32'(out_tw_dir), 32'd0);
    chk("b2b_rd_data", rdv, rdq.pop_front());
    end_frame(10);

    chk("strobes_all_seen", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/threewire_slave_ctrl.md
Name: threewire_slave_ctrl

Overview:
- Responder end of the 3-wire serial link driven by threewire_master_ctrl.
- Deserialises command, address and write-data frames from an external master and issues single-cycle register write/read strobes to a local register file.
- Serialises read data back onto the shared data line.
- Placed in FPGA designs that emulate a 3-wire peripheral for loopback test of the host 3-wire bridge.

Parameters:
- TWS_ADDRESS_BITS, 10, address field width in bits.
- TWS_DATA_BITS, 32, data field width in bits.

Ports:
- in_clk  input  1  system clock; must be at least 8x the 3-wire clock rate.
- in_rst  input  1  reset, asynchronous, active-high.
- in_tw_clock  input  1  3-wire clock from master; idles low.
- in_tw_cs  input  1  chip select from master, active-low.
- io_tw_data  inout  1  bidirectional serial data; driven only while out_tw_dir=1, else Z.
- out_tw_dir  output  1  1 = slave drives io_tw_data.
- out_reg_addr  output  TWS_ADDRESS_BITS  captured address.
- out_reg_wr_data  output  TWS_DATA_BITS  captured write data.
- out_reg_wr  output  1  one-cycle write strobe.
- out_reg_rd  output  1  one-cycle read strobe.
- in_reg_rd_data  input  TWS_DATA_BITS  read data; must be valid the cycle after out_reg_rd.
- out_busy  output  1  high while a frame is in progress (CS low, state not IDLE).

Behaviour:
- Reset values: out_tw_dir=0, out_reg_addr=0, out_reg_wr_data=0, out_reg_wr=0, out_reg_rd=0, out_busy=0; state IDLE.
- Input sampling:
  - in_tw_clock, in_tw_cs and io_tw_data each pass through a 2-FF synchroniser on in_clk.
  - Rise/fall of the synchronised clock is detected by a third register.
  - All detection is therefore delayed 2-3 in_clk cycles.
- Frame format, MSB first, master shifts on falling edge, slave samples on rising edge:
  - 1 R/W bit (1 = write),
  - then TWS_ADDRESS_BITS address bits,
  - then TWS_DATA_BITS data bits (written by master, or returned by slave).
- Bit counter: width clog2(max(TWS_ADDRESS_BITS, TWS_DATA_BITS)); loaded with field length-1, decremented per rising edge.
- States:
  - IDLE: wait for synchronised CS low -> CMD; clear shift registers.
  - CMD: on first rising edge, latch R/W bit -> ADDR.
  - ADDR: shift address bits. On the last address rising edge, update out_reg_addr in the same cycle.
    - Write frame -> WDATA.
    - Read frame -> pulse out_reg_rd for 1 cycle; the next cycle latch in_reg_rd_data into the TX shift register -> RDATA.
  - WDATA: shift data bits. After the last data rising edge, update out_reg_wr_data, pulse out_reg_wr for exactly 1 cycle -> DONE.
  - RDATA:
    - On the first falling edge after the address, set out_tw_dir=1 and drive the data MSB.
    - Each subsequent falling edge presents the next bit.
    - The falling edge after the last bit clears out_tw_dir -> DONE.
  - DONE: ignore all further clocks until CS high -> IDLE.
- CS high in any non-IDLE state:
  - abort -> IDLE, out_tw_dir=0 within 3 in_clk cycles;
  - no out_reg_wr is issued for an incomplete write;
  - out_reg_rd already issued is not retracted.
- out_reg_wr and out_reg_rd are never high in the same cycle; at most one strobe per frame.
- Edges seen while CS is synchronised high are ignored.
- CS falling and clock rising in the same in_clk cycle: CS is processed first; that edge is not counted as a bit.
- Back-to-back frames: a CS high pulse of at least 3 in_clk cycles between frames is required and sufficient.
- Reset mid-frame: all outputs return to reset values immediately; the bus is released asynchronously.

Test Plan:
- Write frame, R/W=1, addr 0x155, data 0xDEADBEEF -> single out_reg_wr pulse with out_reg_addr=0x155 and out_reg_wr_data=0xDEADBEEF; out_tw_dir stays 0 throughout.
- Read frame, addr 0x2AA, in_reg_rd_data=0x12345678 -> single out_reg_rd pulse with addr 0x2AA; master samples 0x12345678 MSB-first on 32 rising edges; out_tw_dir drops after the 32nd bit.
- Write aborted, CS high after 20 data bits -> no out_reg_wr; state IDLE and out_busy=0 within 3 in_clk cycles.
- Read with extra clocks: 40 clocks after the address -> exactly 32 bits driven, then Z; no second strobe.
- in_rst asserted mid-read (after data bit 10) -> out_tw_dir=0 asynchronously; next full write frame (addr 0x001, data 0x00000001) completes correctly.
- Back-to-back: write 0x3FF/0xFFFFFFFF, then read 0x3FF with 3-cycle CS gap -> both strobes issued, read data serialised correctly.
